mod11_load_arbiter: RTL and testbench

MOD11_LOAD_ARBITER -- requirements
Module: mod11_load_arbiter

---
 rtl/mod11_ctrl_pkg.sv | 19 +
 rtl/rr_arb2.sv | 15 +
 rtl/mod11_load_arbiter.sv | 118 +++++++++++
 tb/tb_mod11_load_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod11_ctrl_pkg.sv
// Shared definitions for the mod-11 counter load arbiter: FSM encoding,
// default terminal count / wrap count, and a small one-hot helper.
package mod11_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_COUNT_DEF = 10;
  localparam int RUN_WRAPS_DEF = 1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on contention the requester that was
// served last loses; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

  always_comb begin
    sel = 1'b0;
    if (req == 2'b11) sel = ~last;
    else if (req[1])  sel = 1'b1;
  end

endmodule

// File: rtl/mod11_load_arbiter.sv
// Arbitrates two requesters for an external mod-(MAX_COUNT+1) counter: loads the
// winner's start value, counts RUN_WRAPS terminal counts, then reports completion.
module mod11_load_arbiter
  import mod11_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int RUN_WRAPS = RUN_WRAPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] ld0,
  input  logic [3:0] ld1,
  input  logic       abort,
  input  logic [3:0] count,
  output logic [3:0] ld,
  output logic       ld_enb,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic       busy,
  output logic       owner
);

  localparam logic [3:0] MAX4   = 4'(MAX_COUNT);
  localparam logic [3:0] WRAPS4 = 4'(RUN_WRAPS);

  state_t     state;
  logic       last;
  logic [3:0] wraps;
  logic       sel;
  logic [3:0] sel_val;
  logic       tc;

  rr_arb2 u_rr (
    .req  (req),
    .last (last),
    .sel  (sel)
  );

  assign sel_val = sel ? ld1 : ld0;
  assign tc      = (count == MAX4);

  // A grant is withheld for one cycle after a gnt or err pulse so that a
  // request still held high can never stretch either pulse past one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      wraps  <= 4'd0;
      ld     <= 4'd0;
      ld_enb <= 1'b0;
      gnt    <= 2'b00;
      done   <= 2'b00;
      err    <= 1'b0;
      busy   <= 1'b0;
      owner  <= 1'b0;
    end else begin
      gnt    <= 2'b00;
      done   <= 2'b00;
      err    <= 1'b0;
      ld_enb <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00 && gnt == 2'b00 && !err) begin
            gnt <= onehot2(sel);
            if (sel_val <= MAX4) begin
              ld     <= sel_val;
              ld_enb <= 1'b1;
              owner  <= sel;
              busy   <= 1'b1;
              wraps  <= 4'd0;
              state  <= LOAD;
            end else begin
              err  <= 1'b1;
              last <= sel;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            last  <= owner;
            state <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // Abort outranks a terminal count arriving in the same cycle.
          if (abort) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            wraps <= 4'd0;
            last  <= owner;
            state <= IDLE;
          end else if (tc) begin
            if (wraps + 4'd1 == WRAPS4) begin
              wraps <= 4'd0;
              state <= DONE;
            end else begin
              wraps <= wraps + 4'd1;
            end
          end
        end
        DONE: begin
          done  <= onehot2(owner);
          busy  <= 1'b0;
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod11_load_arbiter.sv
// Bench for mod11_load_arbiter with a behavioural mod-11 counter attached and a
// transaction-level expectation model (priority holder, run length by arithmetic).
module tb_mod11_load_arbiter;

  localparam int MAXC = 10;
  localparam int W    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] ld0 = 4'd0;
  logic [3:0] ld1 = 4'd0;
  logic       abort = 1'b0;
  logic [3:0] count = 4'd0;
  logic [3:0] ld;
  logic       ld_enb;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic       busy;
  logic       owner;

  int   checks = 0;
  int   errors = 0;
  logic pref   = 1'b0;

  mod11_load_arbiter #(.MAX_COUNT(MAXC), .RUN_WRAPS(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ld0    (ld0),
    .ld1    (ld1),
    .abort  (abort),
    .count  (count),
    .ld     (ld),
    .ld_enb (ld_enb),
    .gnt    (gnt),
    .done   (done),
    .err    (err),
    .busy   (busy),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  // External loadable mod-(MAXC+1) counter.
  always_ff @(posedge clk) begin
    if (ld_enb)                  count <= ld;
    else if (count == 4'(MAXC))  count <= 4'd0;
    else                         count <= count + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request transaction: expected winner from the priority holder, expected
  // run length from the start value: (MAXC-v) cycles to the first terminal
  // count, then (MAXC+1) per further wrap.
  task automatic serve(input logic [1:0] r, input logic [3:0] v0, input logic [3:0] v1,
                       input int abort_at, input bit hold_other, output int waited);
    logic       exp_i;
    logic [1:0] exp_g;
    logic [3:0] v;
    int         run_len;
    exp_i = (r == 2'b11) ? pref : r[1];
    exp_g = exp_i ? 2'b10 : 2'b01;
    v     = exp_i ? v1 : v0;
    req = r; ld0 = v0; ld1 = v1;
    waited = 0;
    do begin
      @(posedge clk); #1; waited++;
    end while (gnt == 2'b00 && waited < 30);
    checks++;
    if (gnt !== exp_g) begin
      errors++;
      $display("FAIL grant: got %b expected %b", gnt, exp_g);
      req = 2'b00;
      return;
    end
    req = hold_other ? (r & ~exp_g) : 2'b00;
    if (int'(v) > MAXC) begin
      checks++;
      if ({err, ld_enb, busy} !== 3'b100) begin
        errors++;
        $display("FAIL reject_flags: got err/ld_enb/busy=%b expected 100", {err, ld_enb, busy});
      end
      pref = ~exp_i;
      @(posedge clk); #1;
      checks++;
      if ({gnt, err} !== 3'b000) begin
        errors++;
        $display("FAIL reject_pulse_len: got gnt/err=%b expected 000", {gnt, err});
      end
      return;
    end
    checks++;
    if ({ld_enb, busy, err} !== 3'b110 || ld !== v || owner !== exp_i) begin
      errors++;
      $display("FAIL load: got ld_enb/busy/err=%b ld=%0d owner=%b expected 110 ld=%0d owner=%b",
               {ld_enb, busy, err}, ld, owner, v, exp_i);
    end
    run_len = (MAXC - int'(v)) + (MAXC + 1) * (W - 1) + 1;
    for (int k = 0; k < run_len; k++) begin
      @(posedge clk); #1;
      checks++;
      if (count !== 4'((int'(v) + k) % (MAXC + 1)) || {busy, ld_enb, done, err} !== 5'b10000) begin
        errors++;
        $display("FAIL run_cycle%0d: got count=%0d busy/ld_enb/done/err=%b expected count=%0d 10000",
                 k, count, {busy, ld_enb, done, err}, (int'(v) + k) % (MAXC + 1));
      end
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if ({err, busy, done} !== 4'b1000) begin
          errors++;
          $display("FAIL abort: got err/busy/done=%b expected 1000", {err, busy, done});
        end
        pref = ~exp_i;
        @(posedge clk); #1;
        checks++;
        if ({err, done, gnt} !== 5'b00000) begin
          errors++;
          $display("FAIL abort_after: got err/done/gnt=%b expected 00000", {err, done, gnt});
        end
        return;
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL done_state: got busy/done=%b expected 100", {busy, done});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== exp_g || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b expected done=%b busy=0", done, busy, exp_g);
    end
    pref = ~exp_i;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ld, ld_enb, gnt, done, err, busy, owner} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero", {ld, ld_enb, gnt, done, err, busy, owner});
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    pref = 1'b0;
  endtask

  task automatic test_single_run();
    int w;
    serve(2'b01, 4'd3, 4'd0, -1, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    @(posedge clk); #1;
    serve(2'b11, 4'd5, 4'd7, -1, 1'b1, w);
    serve(2'b10, 4'd5, 4'd7, -1, 1'b0, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL back_to_back_latency: got %0d cycles expected 1", w);
    end
  endtask

  task automatic test_reject();
    int w;
    @(posedge clk); #1;
    serve(2'b10, 4'd0, 4'd12, -1, 1'b0, w);
    serve(2'b11, 4'd9, 4'd4, -1, 1'b0, w);
  endtask

  task automatic test_abort();
    int w;
    @(posedge clk); #1;
    serve(2'b01, 4'd3, 4'd0, 3, 1'b0, w);
  endtask

  task automatic test_first_cycle_wrap();
    int w;
    @(posedge clk); #1;
    serve(2'b01, 4'd10, 4'd0, -1, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    int ab;
    logic [1:0] r;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      r  = 2'($urandom_range(1, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      serve(r, 4'($urandom_range(0, 12)), 4'($urandom_range(0, 12)), ab, 1'b0, w);
    end
  endtask

  task automatic test_reset_midrun();
    int w;
    int t;
    @(posedge clk); #1;
    req = 2'b01; ld0 = 4'd2;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (gnt == 2'b00 && t < 30);
    req = 2'b00;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({ld, ld_enb, gnt, done, err, busy, owner} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got %b expected all zero", {ld, ld_enb, gnt, done, err, busy, owner});
    end
    pref = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_discard: got done/busy=%b expected 000", {done, busy});
    end
    serve(2'b11, 4'd8, 4'd6, -1, 1'b0, w);
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_reject();
    test_abort();
    test_first_cycle_wrap();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
